reg_file: RTL and testbench
===========================

# reg_file

Parametrised multi-entry register file replacing the single-entry bus register in the datapath. Holds `DEPTH` words of `WIDTH` bits. Provides one synchronous write port and two independently addressed registered read ports that drive the A and B operand buses. A background clear sequencer zeroes the array one entry per cycle on request, so a soft clear needs no reset.

## Interface
Parameters:
- `WIDTH`, 16, data width of each entry and of the A/B buses
- `DEPTH`, 8, number of entries (≥2; need not be a power of two)
- `AW`, `$clog2(DEPTH)`, address width (localparam, derived)

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst`  in  1  reset: asynchronous, active-low
- `writeC`  in  1  write enable
- `waddr`  in  AW  write address
- `D`  in  WIDTH  write data
- `raddr_a`  in  AW  read address, port A
- `raddr_b`  in  AW  read address, port B
- `A`  out  WIDTH  registered read data, port A
- `B`  out  WIDTH  registered read data, port B
- `clr`  in  1  single-cycle soft-clear request
- `busy`  out  1  high while the clear sweep runs

## Operation
- Reset (`rst`=0): all entries, `A`, `B` = 0; FSM = IDLE; `busy` = 0; sweep index = 0.
- IDLE state:
  - `writeC`=1 with `waddr` < `DEPTH` writes `D` at the edge.
  - `waddr` ≥ `DEPTH` writes nothing.
- Reads:
  - `A` ← entry[`raddr_a`], `B` ← entry[`raddr_b`] every edge. There is no hold.
  - An address ≥ `DEPTH` reads 0.
- Write-through bypass: if `writeC`=1, the write is valid, and `raddr_x` == `waddr` in the same cycle, that port loads `D` rather than the old contents.
  - Applies to A and B independently, and to both at once.
- FSM states:
  - IDLE → CLEAR on `clr`=1; sweep index ← 0.
  - CLEAR: entry[index] ← 0 each edge, index increments.
  - After clearing entry `DEPTH`-1: → IDLE, index ← 0.
- While in CLEAR:
  - `writeC` is ignored, and the dropped write is not retried.
  - `A` and `B` load 0.
  - `clr` is ignored, so there is no restart.
- `clr` and `writeC` in the same IDLE cycle: the write completes and the sweep then starts. The written entry is cleared by the sweep.
- `rst` asserted mid-sweep: immediate return to the reset state. The sweep is not resumed.

## Timing
- Read latency: 1 cycle. Address presented before edge k, data on `A`/`B` after edge k.
- Write latency: visible on a read issued in the same cycle (bypass). Stored at edge k.
- `clr` sampled at edge k:
  - `busy`=1 after edge k.
  - Entry i cleared at edge k+1+i.
  - `busy`=0 after edge k+`DEPTH`.
  - Total `busy` duration: `DEPTH` cycles.
- A write issued in the first cycle with `busy`=0 is accepted.
- `busy` is a registered output.

## Configuration
- `REGFILE_ZERO_REG_EN` defined:
  - Entry 0 is hardwired to zero. Writes to address 0 are dropped.
  - Reads of address 0 return 0, including the bypass case.
  - The sweep still takes `DEPTH` cycles.
- Undefined: entry 0 is an ordinary register.

## Structure
- Shared package `reg_file_pkg` holds:
  - default `WIDTH`/`DEPTH` constants
  - the FSM state type (`RF_IDLE`, `RF_CLEAR`)
- Sub-module `reg_file_clr_seq` contains the FSM, the sweep index counter and `busy`. Its outputs are:
  - a clear-enable
  - the clear index
- The top module holds the array, the write mux, the bypass logic and the output registers.

## Test plan
- Reset check: hold `rst`=0, then release → `A`=`B`=0; read all 8 addresses → every result is 0; `busy`=0.
- Write/read: write 16'hA5A5 to addr 3 and 16'h1234 to addr 5; then read a=3, b=5 → next cycle `A`=16'hA5A5, `B`=16'h1234.
- Bypass: entry 2 holds 16'h0001; `writeC`=1, `waddr`=2, `D`=16'hBEEF, `raddr_a`=`raddr_b`=2 in the same cycle → next cycle `A`=`B`=16'hBEEF.
- Clear sweep: fill all entries with 16'hFFFF; pulse `clr` → `busy` high for exactly 8 cycles; a write to addr 1 during `busy` is dropped; afterwards all reads return 0.
- Reset mid-sweep: pulse `clr`, then assert `rst` on cycle 3 → `busy`=0 at once and all entries read 0; a write after release succeeds.
- With `REGFILE_ZERO_REG_EN`: write 16'h7777 to addr 0 with `raddr_a`=0 → `A`=0 both that cycle and later; addr 1 is unaffected.

Source files
------------

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants and types for the reg_file register file.
//   RF_WIDTH_DEF / RF_DEPTH_DEF : default data width and entry count
//   rf_state_e                  : clear-sequencer FSM state (RF_IDLE, RF_CLEAR)
package reg_file_pkg;

  localparam int RF_WIDTH_DEF = 16;
  localparam int RF_DEPTH_DEF = 8;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/reg_file_clr_seq.sv
// reg_file_clr_seq: background clear sequencer for reg_file.
// On a clr pulse in IDLE it walks an index from 0 to DEPTH-1, asserting
// clr_en for one cycle per entry, then returns to IDLE.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   clr      in   single-cycle clear request (ignored while sweeping)
//   busy     out  registered, high while the sweep runs
//   clr_en   out  high when entry clr_idx is to be zeroed at the next edge
//   clr_idx  out  entry being cleared this cycle
module reg_file_clr_seq
  import reg_file_pkg::*;
#(
  parameter  int DEPTH = RF_DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic          busy,
  output logic          clr_en,
  output logic [AW-1:0] clr_idx
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  rf_state_e     state_reg, state_next;
  logic [AW-1:0] idx_reg, idx_next;
  logic          busy_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= RF_IDLE;
      idx_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      // busy follows the state being entered so it is a true flop output
      busy_reg  <= (state_next == RF_CLEAR);
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      RF_IDLE: begin
        if (clr) begin
          state_next = RF_CLEAR;
          idx_next   = '0;
        end
      end
      RF_CLEAR: begin
        if (idx_reg == LAST_IDX) begin
          state_next = RF_IDLE;
          idx_next   = '0;
        end else begin
          idx_next = idx_reg + AW'(1);
        end
      end
      default: begin
        state_next = RF_IDLE;
        idx_next   = '0;
      end
    endcase
  end

  assign busy    = busy_reg;
  assign clr_en  = (state_reg == RF_CLEAR);
  assign clr_idx = idx_reg;

endmodule

// File: rtl/reg_file.sv
// reg_file: DEPTH x WIDTH register file, one write port, two registered
// read ports (A and B operand buses) with write-through bypass, and a
// background soft-clear sweep (one entry per cycle).
// Optional build macro: REGFILE_ZERO_REG_EN -- entry 0 hardwired to zero.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   writeC   in   write enable (ignored during a sweep)
//   waddr    in   write address; >= DEPTH writes nothing
//   D        in   write data
//   raddr_a  in   read address, port A; >= DEPTH reads 0
//   raddr_b  in   read address, port B; >= DEPTH reads 0
//   A        out  registered read data, port A
//   B        out  registered read data, port B
//   clr      in   single-cycle soft-clear request
//   busy     out  high while the clear sweep runs
module reg_file
  import reg_file_pkg::*;
#(
  parameter  int WIDTH = RF_WIDTH_DEF,
  parameter  int DEPTH = RF_DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             writeC,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  input  logic             clr,
  output logic             busy
);

  // One extra bit so DEPTH itself is representable for the range checks.
  localparam logic [AW:0] DEPTH_EXT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;

  logic          clr_en;
  logic [AW-1:0] clr_idx;
  logic          addr_writable;
  logic          zero_a, zero_b;
  logic          waddr_ok, raddr_a_ok, raddr_b_ok;
  logic          wr_en;

  reg_file_clr_seq #(
    .DEPTH (DEPTH)
  ) u_clr_seq (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .busy    (busy),
    .clr_en  (clr_en),
    .clr_idx (clr_idx)
  );

`ifdef REGFILE_ZERO_REG_EN
  // Entry 0 is never written, so it keeps its reset value of zero; reads of
  // address 0 are forced to zero as well so the bypass cannot leak D.
  assign addr_writable = (waddr != '0);
  assign zero_a        = (raddr_a == '0);
  assign zero_b        = (raddr_b == '0);
`else
  assign addr_writable = 1'b1;
  assign zero_a        = 1'b0;
  assign zero_b        = 1'b0;
`endif

  assign waddr_ok   = ({1'b0, waddr}   < DEPTH_EXT);
  assign raddr_a_ok = ({1'b0, raddr_a} < DEPTH_EXT);
  assign raddr_b_ok = ({1'b0, raddr_b} < DEPTH_EXT);

  // Writes are dropped (not deferred) while the sweep owns the array.
  assign wr_en = writeC && !clr_en && waddr_ok && addr_writable;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clr_en && (clr_idx == AW'(i))) begin
          mem_reg[i] <= '0;
        end else if (wr_en && (waddr == AW'(i))) begin
          mem_reg[i] <= D;
        end
      end
    end
  end

  // Read port A: zero during a sweep, zero for out-of-range or hardwired
  // entry, write data when reading the address being written this cycle.
  always_comb begin
    a_next = '0;
    if (!clr_en && raddr_a_ok && !zero_a) begin
      if (wr_en && (raddr_a == waddr)) begin
        a_next = D;
      end else begin
        a_next = mem_reg[raddr_a];
      end
    end
  end

  always_comb begin
    b_next = '0;
    if (!clr_en && raddr_b_ok && !zero_b) begin
      if (wr_en && (raddr_b == waddr)) begin
        b_next = D;
      end else begin
        b_next = mem_reg[raddr_b];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      a_reg <= a_next;
      b_reg <= b_next;
    end
  end

  assign A = a_reg;
  assign B = b_reg;

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed, self-checking bench for reg_file (8 x 16).
// A behavioural model predicts A/B/busy for every cycle; predictions are
// queued when the stimulus is driven and popped after the clock edge.
module tb_reg_file;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          writeC = 1'b0;
  logic          clr = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [AW-1:0] raddr_a = '0;
  logic [AW-1:0] raddr_b = '0;
  logic [W-1:0]  D = '0;
  logic [W-1:0]  A, B;
  logic          busy;

  reg_file #(
    .WIDTH (W),
    .DEPTH (N)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .writeC  (writeC),
    .waddr   (waddr),
    .D       (D),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .A       (A),
    .B       (B),
    .clr     (clr),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bsy;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] model [N];
  bit           m_busy;
  int           m_idx;
  bit           zr;
  int           vectors = 0;
  int           miscompares = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) model[i] = '0;
    m_busy = 1'b0;
    m_idx  = 0;
  endtask

  // One clock of stimulus: drive, predict, advance, compare.
  task automatic step(input string tag, input bit wc, input int wa, input logic [W-1:0] d,
                      input int ra, input int rb, input bit c);
    exp_t e;
    bit   vw;
    writeC  = wc;
    waddr   = AW'(wa);
    D       = d;
    raddr_a = AW'(ra);
    raddr_b = AW'(rb);
    clr     = c;
    vw = wc && !m_busy && !(zr && wa == 0);
    e.a = m_busy ? '0 : (zr && ra == 0) ? '0 : (vw && ra == wa) ? d : model[ra];
    e.b = m_busy ? '0 : (zr && rb == 0) ? '0 : (vw && rb == wa) ? d : model[rb];
    if (m_busy) begin
      model[m_idx] = '0;
      if (m_idx == N - 1) begin
        m_busy = 1'b0;
        m_idx  = 0;
      end else begin
        m_idx++;
      end
    end else begin
      if (vw) model[wa] = d;
      if (c) begin
        m_busy = 1'b1;
        m_idx  = 0;
      end
    end
    e.bsy = m_busy;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    $display("%-10s wc=%0d wa=%0d d=%h ra=%0d rb=%0d clr=%0d -> A=%h B=%h busy=%0d",
             tag, wc, wa, d, ra, rb, c, A, B, busy);
    chk({tag, ".A"}, A, e.a);
    chk({tag, ".B"}, B, e.b);
    chk({tag, ".busy"}, {15'b0, busy}, {15'b0, e.bsy});
    writeC = 1'b0;
    clr    = 1'b0;
  endtask

  initial begin
`ifdef REGFILE_ZERO_REG_EN
    zr = 1'b1;
`else
    zr = 1'b0;
`endif
    model_reset();

    // Reset state
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.A", A, '0);
    chk("reset.B", B, '0);
    chk("reset.busy", {15'b0, busy}, '0);
    #2 rst = 1'b1;
    for (int i = 0; i < N; i++) step("rd_reset", 1'b0, 0, '0, i, N - 1 - i, 1'b0);

    // Plain write then read
    step("wr3", 1'b1, 3, 16'hA5A5, 0, 1, 1'b0);
    step("wr5", 1'b1, 5, 16'h1234, 6, 7, 1'b0);
    step("rd35", 1'b0, 0, '0, 3, 5, 1'b0);

    // Write-through bypass on both ports, then on one port only
    step("wr2", 1'b1, 2, 16'h0001, 4, 4, 1'b0);
    step("byp2", 1'b1, 2, 16'hBEEF, 2, 2, 1'b0);
    step("rd2", 1'b0, 0, '0, 2, 3, 1'b0);
    step("bypA", 1'b1, 6, 16'hC0DE, 6, 5, 1'b0);
    step("bypB", 1'b1, 7, 16'h0F0F, 3, 7, 1'b0);

    // Clear sweep: fill, clr together with a write, write during busy dropped
    for (int i = 0; i < N; i++) step("fill", 1'b1, i, 16'hFFFF, i, 0, 1'b0);
    step("clr_wr", 1'b1, 6, 16'h1111, 6, 1, 1'b1);
    step("sweep_wr", 1'b1, 1, 16'h2222, 1, 1, 1'b0);
    for (int i = 1; i < N; i++) step("sweep", 1'b0, 0, '0, 1, i, 1'b1);
    step("post_wr", 1'b1, 4, 16'h4444, 4, 6, 1'b0);
    for (int i = 0; i < N; i++) step("rd_clr", 1'b0, 0, '0, i, N - 1 - i, 1'b0);

    // Entry 0 (hardwired zero only with the option enabled)
    step("wr0", 1'b1, 0, 16'h7777, 0, 1, 1'b0);
    step("wr1", 1'b1, 1, 16'h5A5A, 0, 1, 1'b0);
    step("rd01", 1'b0, 0, '0, 0, 1, 1'b0);

    // Reset in the middle of a sweep
    step("clr2", 1'b0, 0, '0, 1, 0, 1'b1);
    step("sw_a", 1'b0, 0, '0, 1, 0, 1'b0);
    step("sw_b", 1'b0, 0, '0, 1, 0, 1'b0);
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_mid.busy", {15'b0, busy}, '0);
    chk("rst_mid.A", A, '0);
    chk("rst_mid.B", B, '0);
    @(posedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < N; i++) step("rd_rst", 1'b0, 0, '0, i, (i + 3) % N, 1'b0);
    step("wr_after", 1'b1, 5, 16'h5555, 0, 0, 1'b0);
    step("rd_after", 1'b0, 0, '0, 5, 4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
